// File: rtl/wr_burst_packer.sv
// Write-burst packer: buffers upstream words in a show-ahead FIFO and emits them as
// fixed-length (or flushed partial) address+data bursts with an auto-incrementing byte address.
module wr_burst_packer #(
  parameter int DATA_WIDTH     = 160,
  parameter int ADDR_W         = 32,
  parameter int BURST_LEN      = 16,
  parameter int FIFO_ADDR_W    = 5,
  parameter int LEN_W          = $clog2(BURST_LEN),
  parameter int BYTES_PER_BEAT = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     cfg_base_addr,
  input  logic                  cfg_start,
  input  logic                  s_write_req,
  output logic                  s_write_ready,
  input  logic [DATA_WIDTH-1:0] s_write_data,
  input  logic                  s_write_flush,
  output logic                  m_wr_req,
  input  logic                  m_wr_ready,
  output logic [ADDR_W-1:0]     m_wr_addr,
  output logic [LEN_W-1:0]      m_wr_len,
  output logic                  m_wdata_valid,
  input  logic                  m_wdata_ready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_wdata_last,
  output logic                  busy
);

  localparam int                 DEPTH     = 1 << FIFO_ADDR_W;
  localparam logic [FIFO_ADDR_W:0] CNT_FULL  = (FIFO_ADDR_W + 1)'(DEPTH);
  localparam logic [FIFO_ADDR_W:0] CNT_BURST = (FIFO_ADDR_W + 1)'(BURST_LEN);
  localparam logic [FIFO_ADDR_W:0] CNT_ONE   = (FIFO_ADDR_W + 1)'(1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [FIFO_ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [FIFO_ADDR_W:0]   count;
  logic                   full, empty, push, pop, last_hs;
  logic [LEN_W-1:0]       len_q, len_d, beat_cnt;
  logic                   len_load;
  logic [ADDR_W-1:0]      addr_ptr, addr_step;
  logic                   flush_pending;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);
  // Gated by reset so every output reads 0 while reset is held.
  assign s_write_ready = reset & ~full;
  assign push    = s_write_req & s_write_ready;
  assign pop     = m_wdata_valid & m_wdata_ready;
  assign last_hs = pop & m_wdata_last;

  // NOTE: the storage array has no reset; only pointers and count define FIFO contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_write_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_ADDR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  assign m_wdata = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no latches are inferred.
  always_comb begin
    state_d       = state_q;
    m_wr_req      = 1'b0;
    m_wdata_valid = 1'b0;
    m_wdata_last  = 1'b0;
    len_load      = 1'b0;
    len_d         = len_q;
    case (state_q)
      IDLE: begin
        if (count >= CNT_BURST) begin
          len_load = 1'b1;
          len_d    = LEN_W'(BURST_LEN - 1);
          state_d  = ADDR;
        end else if (flush_pending && !empty) begin
          len_load = 1'b1;
          len_d    = LEN_W'(count - CNT_ONE);
          state_d  = ADDR;
        end
      end
      ADDR: begin
        m_wr_req = 1'b1;
        if (m_wr_ready) state_d = DATA;
      end
      DATA: begin
        m_wdata_valid = !empty;
        m_wdata_last  = !empty && (beat_cnt == len_q);
        if (!empty && m_wdata_ready && (beat_cnt == len_q)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign addr_step = (ADDR_W'(len_q) + ADDR_W'(1)) * ADDR_W'(BYTES_PER_BEAT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q         <= '0;
      beat_cnt      <= '0;
      addr_ptr      <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (len_load) len_q <= len_d;
      if (state_q == ADDR && m_wr_ready) beat_cnt <= '0;
      else if (pop)                      beat_cnt <= beat_cnt + LEN_W'(1);
      // Base address is only accepted between bursts so an in-flight burst keeps its address.
      if (state_q == IDLE && cfg_start) addr_ptr <= cfg_base_addr;
      else if (last_hs)                 addr_ptr <= addr_ptr + addr_step;
      if (s_write_flush)                  flush_pending <= 1'b1;
      else if (state_q == IDLE && empty)  flush_pending <= 1'b0;
    end
  end

  assign m_wr_addr = addr_ptr;
  assign m_wr_len  = len_q;
  assign busy      = (state_q != IDLE) || !empty || flush_pending;

endmodule

// File: tb/tb_wr_burst_packer.sv
// Directed self-checking bench for wr_burst_packer: full, flushed, back-pressured,
// address-wrapping and reset-interrupted bursts against a scoreboard of pushed words.
module tb_wr_burst_packer;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  cfg_base_addr;
  logic         cfg_start;
  logic         s_write_req;
  logic         s_write_ready;
  logic [159:0] s_write_data;
  logic         s_write_flush;
  logic         m_wr_req;
  logic         m_wr_ready;
  logic [31:0]  m_wr_addr;
  logic [3:0]   m_wr_len;
  logic         m_wdata_valid;
  logic         m_wdata_ready;
  logic [159:0] m_wdata;
  logic         m_wdata_last;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int word_id = 0;
  logic [159:0] exp_q[$];

  wr_burst_packer dut (
    .clk(clk), .reset(reset),
    .cfg_base_addr(cfg_base_addr), .cfg_start(cfg_start),
    .s_write_req(s_write_req), .s_write_ready(s_write_ready),
    .s_write_data(s_write_data), .s_write_flush(s_write_flush),
    .m_wr_req(m_wr_req), .m_wr_ready(m_wr_ready),
    .m_wr_addr(m_wr_addr), .m_wr_len(m_wr_len),
    .m_wdata_valid(m_wdata_valid), .m_wdata_ready(m_wdata_ready),
    .m_wdata(m_wdata), .m_wdata_last(m_wdata_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] mk_word(input int n);
    return {32'hA000_0000 | 32'(n), 32'h0B00_0000 | 32'(n * 3), 32'h00C0_0000 | 32'(n * 5),
            32'h000D_0000 | 32'(n * 7), ~32'(n)};
  endfunction

  // Offers one word for one cycle; the scoreboard records it only if the DUT can take it.
  task automatic push_word();
    logic [159:0] d;
    d = mk_word(word_id);
    word_id++;
    s_write_req  = 1'b1;
    s_write_data = d;
    if (s_write_ready) exp_q.push_back(d);
    tick();
    s_write_req = 1'b0;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) push_word();
  endtask

  task automatic run_burst(input logic [31:0] exp_addr, input logic [3:0] exp_len,
                           input bit toggle, input bit poke_start, input string tag);
    int waited;
    int beat;
    int cyc;
    bit rdy;
    logic [159:0] head;
    waited = 0;
    while (!m_wr_req && waited < 100) begin
      tick();
      waited++;
    end
    check({tag, "_req"}, m_wr_req, 1'b1);
    check({tag, "_addr"}, m_wr_addr, exp_addr);
    check({tag, "_len"}, m_wr_len, exp_len);
    m_wr_ready = 1'b1;
    tick();
    m_wr_ready = 1'b0;
    beat = 0;
    cyc  = 0;
    while (beat <= int'(exp_len) && cyc < 200) begin
      rdy = toggle ? (cyc % 2 == 0) : 1'b1;
      m_wdata_ready = rdy;
      cfg_start     = poke_start && (cyc == 1);
      cfg_base_addr = poke_start ? 32'hDEAD_0000 : cfg_base_addr;
      head = (exp_q.size() > 0) ? exp_q[0] : '0;
      check({tag, "_valid"}, m_wdata_valid, 1'b1);
      check({tag, "_data"}, m_wdata, head);
      check({tag, "_last"}, m_wdata_last, beat == int'(exp_len));
      tick();
      if (rdy) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        beat++;
      end
      cyc++;
    end
    m_wdata_ready = 1'b0;
    cfg_start     = 1'b0;
    check({tag, "_done"}, (beat == int'(exp_len) + 1), 1'b1);
  endtask

  initial begin
    int waited;
    reset = 1'b0;
    cfg_base_addr = '0;
    cfg_start = 1'b0;
    s_write_req = 1'b0;
    s_write_data = '0;
    s_write_flush = 1'b0;
    m_wr_ready = 1'b0;
    m_wdata_ready = 1'b0;
    tick();
    tick();
    check("rst_req", m_wr_req, 1'b0);
    check("rst_valid", m_wdata_valid, 1'b0);
    check("rst_last", m_wdata_last, 1'b0);
    check("rst_ready", s_write_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_addr", m_wr_addr, 32'h0);
    check("rst_len", m_wr_len, 4'h0);
    check("rst_wdata", m_wdata, '0);
    reset = 1'b1;
    tick();
    check("post_rst_ready", s_write_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);

    // Full burst from base 0x1000, including the 2-cycle request latency.
    cfg_base_addr = 32'h0000_1000;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    push_n(16);
    check("t1_req_lat1", m_wr_req, 1'b0);
    tick();
    check("t1_req_lat2", m_wr_req, 1'b1);
    run_burst(32'h0000_1000, 4'd15, 1'b0, 1'b0, "t1");
    check("t1_busy", busy, 1'b0);
    check("t1_next_addr", m_wr_addr, 32'h0000_1140);

    // Flushed partial burst of 5 beats.
    push_n(5);
    tick();
    check("t2_no_req", m_wr_req, 1'b0);
    s_write_flush = 1'b1;
    tick();
    s_write_flush = 1'b0;
    run_burst(32'h0000_1140, 4'd4, 1'b0, 1'b0, "t2");
    check("t2_busy_hold", busy, 1'b1);
    tick();
    check("t2_busy_fall", busy, 1'b0);
    check("t2_next_addr", m_wr_addr, 32'h0000_11A4);

    // Fill the buffer with the address channel stalled; extra words must be dropped.
    push_n(32);
    check("t3_full", s_write_ready, 1'b0);
    push_n(2);
    check("t3_still_full", s_write_ready, 1'b0);
    run_burst(32'h0000_11A4, 4'd15, 1'b0, 1'b0, "t3a");
    check("t3_ready_back", s_write_ready, 1'b1);
    check("t3_idle_gap", m_wr_req, 1'b0);
    tick();
    check("t3_b2b_req", m_wr_req, 1'b1);
    // Second burst runs with beat-ready toggling 1010...
    run_burst(32'h0000_12E4, 4'd15, 1'b1, 1'b0, "t4");
    check("t4_busy", busy, 1'b0);
    check("t4_next_addr", m_wr_addr, 32'h0000_1424);

    // Address wrap; cfg_start pulsed mid-burst must be ignored.
    cfg_base_addr = 32'hFFFF_FF00;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    push_n(16);
    run_burst(32'hFFFF_FF00, 4'd15, 1'b0, 1'b1, "t5");
    check("t5_wrap_addr", m_wr_addr, 32'h0000_0040);

    // Reset in the middle of a burst after 7 accepted beats.
    push_n(16);
    waited = 0;
    while (!m_wr_req && waited < 100) begin
      tick();
      waited++;
    end
    check("t6_req", m_wr_req, 1'b1);
    m_wr_ready = 1'b1;
    tick();
    m_wr_ready = 1'b0;
    m_wdata_ready = 1'b1;
    repeat (7) tick();
    check("t6_mid_valid", m_wdata_valid, 1'b1);
    reset = 1'b0;
    #1;
    check("t6_rst_valid", m_wdata_valid, 1'b0);
    check("t6_rst_last", m_wdata_last, 1'b0);
    check("t6_rst_req", m_wr_req, 1'b0);
    check("t6_rst_ready", s_write_ready, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_addr", m_wr_addr, 32'h0);
    check("t6_rst_wdata", m_wdata, '0);
    m_wdata_ready = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("t6_rel_busy", busy, 1'b0);
    check("t6_rel_ready", s_write_ready, 1'b1);
    exp_q.delete();
    push_n(16);
    run_burst(32'h0000_0000, 4'd15, 1'b0, 1'b0, "t6");
    check("t6_next_addr", m_wr_addr, 32'h0000_0140);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wr_burst_packer.md
Name: wr_burst_packer

Overview:
- Sits directly downstream of the serializer/deserializer stage and consumes its output word stream (m_write_req / m_write_data).
- Buffers the words and groups them into fixed-length write bursts, with an auto-incrementing byte address, for the memory write master.
- A flush input forces out a final partial burst at the end of a layer.

Parameters:
DATA_WIDTH, 160, beat width; equals the upstream output width (10 x 16 bit).
ADDR_W, 32, byte-address width.
BURST_LEN, 16, beats per full burst; power of two, at most 2^FIFO_ADDR_W.
FIFO_ADDR_W, 5, log2 of buffer depth (32 entries).
LEN_W, C_LOG_2(BURST_LEN), width of the burst-length field.
BYTES_PER_BEAT, DATA_WIDTH/8, address increment per beat.

Ports:
clk  input  1  sole clock; all logic on its rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
cfg_base_addr  input  ADDR_W  start byte address.
cfg_start  input  1  one-cycle pulse; loads cfg_base_addr into the address pointer.
s_write_req  input  1  input word valid (from the upstream m_write_req).
s_write_ready  output  1  buffer can accept a word.
s_write_data  input  DATA_WIDTH  input word.
s_write_flush  input  1  one-cycle pulse: emit any remaining words as a partial burst.
m_wr_req  output  1  burst address request valid.
m_wr_ready  input  1  address accepted.
m_wr_addr  output  ADDR_W  burst start byte address.
m_wr_len  output  LEN_W  beats minus 1.
m_wdata_valid  output  1  write beat valid.
m_wdata_ready  input  1  write beat accepted.
m_wdata  output  DATA_WIDTH  write beat data.
m_wdata_last  output  1  final beat of the burst.
busy  output  1  state != IDLE, or buffer non-empty, or flush pending.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low.
- Reset values: all outputs 0; buffer empty; address pointer 0; flush_pending 0; state IDLE. Asserting reset mid-burst discards buffered data and any in-flight burst.
- Buffer:
  - Show-ahead FIFO of 2^FIFO_ADDR_W entries; m_wdata is the FIFO head.
  - Push when s_write_req && s_write_ready; s_write_ready = !full.
  - s_write_req while full is ignored (word dropped); upstream must honour ready.
  - Push and pop in the same cycle leave the count unchanged.
  - A word pushed in cycle t is counted from cycle t+1.
- Flush: flush_pending is sticky, set by s_write_flush. It clears when the FSM is in IDLE with the buffer empty. If s_write_flush and that clear condition occur together, the set wins.
- Address pointer:
  - cfg_start loads it only in IDLE; ignored in other states.
  - After the last beat handshake it advances by (m_wr_len+1)*BYTES_PER_BEAT, modulo 2^ADDR_W (silent wrap).
- FSM states:
  - IDLE:
    - If count >= BURST_LEN: latch len = BURST_LEN-1 and go to ADDR.
    - Else if flush_pending and count > 0: latch len = count-1 and go to ADDR.
    - Otherwise stay in IDLE.
  - ADDR:
    - m_wr_req = 1; m_wr_addr and m_wr_len are held stable until m_wr_ready.
    - On m_wr_ready go to DATA with beat counter = 0.
  - DATA:
    - m_wdata_valid = !empty.
    - Pop on m_wdata_valid && m_wdata_ready; the beat counter increments on each pop.
    - m_wdata_last = m_wdata_valid && (beat counter == latched len).
    - On the last handshake, update the address and go to IDLE.
- Latency: m_wr_req rises 2 cycles after the push that makes count reach BURST_LEN (count visible t+1, IDLE decision, ADDR at t+2). The first beat can be accepted the cycle after m_wr_ready.
- Partial-burst length is captured once in IDLE. Words arriving later stay for the next burst and never extend the current one.
- m_wdata_valid may drop mid-burst only if the buffer runs empty, which is impossible because the burst length is never larger than the captured count. The verifier checks that valid stays high through DATA.
- Back-to-back bursts: IDLE costs exactly 1 cycle between the last beat and the next m_wr_req.

Test Plan:
1. base 0x1000, cfg_start, push 16 words D0..D15 -> one request addr 0x1000, len 15; beats D0..D15 in order; last only on D15; pointer becomes 0x1140.
2. Push 5 words, then s_write_flush -> request len 4 at current address; 5 beats, last on the 5th; busy falls 1 cycle after the final handshake.
3. Push 32 words with m_wr_ready held 0 -> s_write_ready goes low after the 32nd word; words offered while full are dropped. Release ready -> two bursts of 16 in order; ready reasserts after the first pop.
4. m_wdata_ready toggling 1010… during a burst -> each beat held stable until accepted; no duplicates, no losses.
5. base 0xFFFFFF00 with a 16-beat burst -> next address 0x00000040 (wrap); cfg_start pulsed during DATA is ignored.
6. Reset asserted low in DATA after 7 beats -> all outputs 0 immediately; after release, busy = 0 and s_write_ready = 1; the first new burst starts at address 0.
